// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope generator.
// The level advances on a prescaled tick; gate edges change phase on any clk.
module adsr_envelope #(
  parameter int TICK_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gate,
  input  logic [7:0]  amp_envelope,
  output logic [11:0] env_level,
  output logic [2:0]  env_state,
  output logic        env_active
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [12:0] LEVEL_MAX = 13'd4095;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gate_q, gate_d;

  logic        tick;
  logic        rise;
  logic        fall;
  logic [12:0] step_a;
  logic [12:0] step_d;
  logic [12:0] step_r;
  logic [11:0] sus_level;
  logic [12:0] attack_sum;
  logic [12:0] decay_floor;

  // Code 0 is the fastest rate, code 3 the slowest.
  function automatic logic [12:0] step_of(input logic [1:0] code);
    logic [12:0] s;
    case (code)
      2'd0:    s = 13'd64;
      2'd1:    s = 13'd16;
      2'd2:    s = 13'd4;
      default: s = 13'd1;
    endcase
    return s;
  endfunction

  // Prescaler, gate history and field decode; codes are read live every cycle.
  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    gate_d      = gate;
    rise        = gate & ~gate_q;
    fall        = ~gate & gate_q;
    step_a      = step_of(amp_envelope[1:0]);
    step_d      = step_of(amp_envelope[3:2]);
    step_r      = step_of(amp_envelope[7:6]);
    sus_level   = {6{amp_envelope[5:4]}};
    attack_sum  = {1'b0, level_q} + step_a;
    decay_floor = {1'b0, sus_level} + step_d;
  end

  // State register: phase, level, prescaler count and registered gate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
    end
  end

  // Next phase and level: edges win over the tick, and an edge cycle holds the level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = ST_ATTACK;
    end else if (fall) begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
        state_d = ST_RELEASE;
      end
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          if (attack_sum >= LEVEL_MAX) begin
            level_d = 12'd4095;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[11:0];
          end
        end
        ST_DECAY: begin
          if ({1'b0, level_q} <= decay_floor) begin
            level_d = sus_level;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - step_d[11:0];
          end
        end
        ST_SUSTAIN: begin
          level_d = sus_level;
        end
        ST_RELEASE: begin
          if ({1'b0, level_q} <= step_r) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - step_r[11:0];
          end
        end
        default: begin
          level_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from the registered phase and level.
  always_comb begin
    env_state  = state_q;
    env_level  = level_q;
    env_active = (state_q != ST_IDLE);
  end

endmodule
